// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : 640x480@60 VGA timing generator: pixel-rate divider, x/y counters,
//            hsync/vsync/video_on. Optional frame_tick via VGA_SYNC_FRAME_TICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    output logic       frame_tick
`endif
);

    localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_disp     = 10'(H_DISPLAY);
    localparam logic [9:0] c_v_disp     = 10'(V_DISPLAY);
    localparam logic [9:0] c_hs_start   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_hs_end     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] c_vs_start   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_vs_end     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               w_div_last;
    logic               w_x_last;
    logic               w_y_last;
    logic [9:0]         w_x_next;
    logic [9:0]         w_y_next;
    logic               w_hsync_next;
    logic               w_vsync_next;
    logic               w_video_next;

    assign w_div_last = (r_div_cnt == c_div_last);
    assign w_x_last   = (x == c_h_last);
    assign w_y_last   = (y == c_v_last);

    // Syncs and video_on are derived from the next coordinates so that they
    // register on the same edge as x/y and carry no skew relative to them.
    always_comb begin
        w_x_next     = w_x_last ? 10'd0 : x + 10'd1;
        w_y_next     = y;
        if (w_x_last) begin
            w_y_next = w_y_last ? 10'd0 : y + 10'd1;
        end
        w_hsync_next = !((w_x_next >= c_hs_start) && (w_x_next <= c_hs_end));
        w_vsync_next = !((w_y_next >= c_vs_start) && (w_y_next <= c_vs_end));
        w_video_next = (w_x_next < c_h_disp) && (w_y_next < c_v_disp);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            p_tick    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
            p_tick    <= w_div_last;
        end
    end

    // Counters and timing outputs move only on the pixel boundary; reset
    // values (blanked, syncs idle) hold until the first pixel advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= 10'd0;
            y        <= 10'd0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (w_div_last) begin
            x        <= w_x_next;
            y        <= w_y_next;
            hsync    <= w_hsync_next;
            vsync    <= w_vsync_next;
            video_on <= w_video_next;
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= w_div_last && w_x_last && w_y_last;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Randomised reset/run stimulus for vga_sync_gen with a queue-based
//            scoreboard against an arithmetic model of the frame timing.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_sync_gen;

    // Horizontal timing at production values; vertical shortened to keep
    // two complete frames inside a short run.
    localparam int DIV = 4;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 3,   VF = 2,  VS = 2,  VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * DIV;
    localparam int MAX_FAILS = 50;
`ifdef VGA_SYNC_FRAME_TICK_EN
    localparam bit HAS_FT = 1'b1;
`else
    localparam bit HAS_FT = 1'b0;
`endif

    typedef struct packed {
        logic       p_tick;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       ft;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_tick, hsync, vsync, video_on;
    logic [9:0] x, y;
`ifdef VGA_SYNC_FRAME_TICK_EN
    logic       frame_tick;
`endif

    obs_t exp_q[$];
    int   k = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p_tick(p_tick),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .x(x),
        .y(y)
`ifdef VGA_SYNC_FRAME_TICK_EN
        ,
        .frame_tick(frame_tick)
`endif
    );

    // k = clock edges since reset release (0 while in reset). Pixel count is
    // k/DIV; the screen position is that count modulo the frame size.
    function automatic obs_t model(input int kk);
        obs_t e;
        int   ticks, pos, px, py;
        ticks      = kk / DIV;
        pos        = ticks % (HT * VT);
        px         = pos % HT;
        py         = pos / HT;
        e.x        = 10'(px);
        e.y        = 10'(py);
        e.p_tick   = (kk > 0) && (kk % DIV == 0);
        e.hsync    = !(px >= HD + HF && px < HD + HF + HS);
        e.vsync    = !(py >= VD + VF && py < VD + VF + VS);
        e.video_on = (ticks > 0) && (px < HD) && (py < VD);
        e.ft       = HAS_FT && e.p_tick && (pos == 0);
        return e;
    endfunction

    // One clock: note the edge, then change reset mid-cycle (asynchronously
    // with respect to the DUT) and queue what the outputs must show.
    task automatic step(input logic new_reset);
        @(posedge clk);
        if (reset) k = 0;
        else       k = k + 1;
        #1;
        reset = new_reset;
        if (reset) k = 0;
        exp_q.push_back(model(k));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n && n_fail < MAX_FAILS; i++) step(1'b0);
    endtask

    // Monitor: compare every cycle, away from the active edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.p_tick   = p_tick;
                a.hsync    = hsync;
                a.vsync    = vsync;
                a.video_on = video_on;
                a.x        = x;
                a.y        = y;
`ifdef VGA_SYNC_FRAME_TICK_EN
                a.ft       = frame_tick;
`else
                a.ft       = 1'b0;
`endif
                n_checks++;
                if (a === e) begin
                    n_pass++;
                end else begin
                    n_fail++;
                    $display("FAIL timing t=%0t got x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b exp x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b",
                             $time, a.x, a.y, a.p_tick, a.hsync, a.vsync, a.video_on, a.ft,
                             e.x, e.y, e.p_tick, e.hsync, e.vsync, e.video_on, e.ft);
                end
            end
        end
    end

    initial begin
        #(20_000_000);
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) step(1'b1);
        step(1'b0);
        run($urandom_range(3000, 12000));

        // Mid-frame reset with a random hold, then two whole frames.
        step(1'b1);
        n = $urandom_range(1, 5);
        repeat (n) step(1'b1);
        step(1'b0);
        run(2 * FRAME_CLKS + 200);

        // Short random reset/run bursts, including resets right at pixel edges.
        for (int r = 0; r < 4; r++) begin
            step(1'b1);
            step(1'b0);
            run($urandom_range(1, 3 * DIV));
            run($urandom_range(0, 1500));
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL drain queue_left=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
